alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 108 ++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Drives one op (or all 16 ops) to an external combinational ALU, waits
// SETTLE_CYCLES for the result to settle, then hands it out with valid/ready.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_sweep,
    input  logic [3:0] cmd_sel,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_cout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_cout,
    output logic [3:0] rsp_sel,
    output logic       rsp_last,
    output logic       busy,
    output logic [7:0] rsp_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       sweep_q;
    logic [7:0] a_q, b_q;
    logic [3:0] sel_q;
    logic [7:0] data_q;
    logic       cout_q;
    logic [3:0] rsel_q;
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sweep_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            cout_q  <= 1'b0;
            rsel_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        sel_q   <= cmd_sweep ? 4'h0 : cmd_sel;
                        sweep_q <= cmd_sweep;
                        cnt_q   <= RELOAD;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Sample only once the operands have been held long enough.
                    if (cnt_q == 4'd0) begin
                        data_q  <= alu_out;
                        cout_q  <= alu_cout;
                        rsel_q  <= sel_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        count_q <= count_q + 8'd1;
                        if (sweep_q && sel_q != 4'hF) begin
                            sel_q   <= sel_q + 4'd1;
                            cnt_q   <= RELOAD;
                            state_q <= DRIVE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_last  = (state_q == RESP) && (!sweep_q || sel_q == 4'hF);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign rsp_data  = data_q;
    assign rsp_cout  = cout_q;
    assign rsp_sel   = rsel_q;
    assign rsp_count = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: two sequencers (settle 1 and 4) share stimulus, each with
// its own ALU model; the settle-4 ALU output is corrupted until it should be sampled.
module tb_alu_sequencer;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [3:0] s;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_sweep = 1'b0;
    logic [3:0] cmd_sel = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic       rsp_ready = 1'b0;

    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic       rsp_cout  [2];
    logic       rsp_last  [2];
    logic       busy      [2];
    logic       alu_cout  [2];
    logic [7:0] alu_a [2], alu_b [2], alu_out [2], rsp_data [2], rsp_count [2];
    logic [3:0] alu_sel [2], rsp_sel [2];

    int   total = 0, bad = 0;
    int   cyc = 0, drv_cyc = 0;
    int   rdy_mode = 0;
    int   start [2], hs_cnt [2];
    int   setl [2] = '{1, 4};
    logic pv [2] = '{1'b0, 1'b0};
    logic pr = 1'b0;
    logic [7:0] cnt_exp [2] = '{8'd0, 8'd0};
    exp_t held [2];
    exp_t q0 [$], q1 [$];

    alu_sequencer #(.SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_sweep(cmd_sweep), .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
        .alu_out(alu_out[0]), .alu_cout(alu_cout[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
        .rsp_cout(rsp_cout[0]), .rsp_sel(rsp_sel[0]), .rsp_last(rsp_last[0]),
        .busy(busy[0]), .rsp_count(rsp_count[0]));

    alu_sequencer #(.SETTLE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_sweep(cmd_sweep), .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
        .alu_out(alu_out[1]), .alu_cout(alu_cout[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
        .rsp_cout(rsp_cout[1]), .rsp_sel(rsp_sel[1]), .rsp_last(rsp_last[1]),
        .busy(busy[1]), .rsp_count(rsp_count[1]));

    // ALU model: 0 add, 1 subtract, 8 and, others an arbitrary mix.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
        case (s)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a} - {1'b0, b};
            4'h8:    return {1'b0, a & b};
            default: return {s[0], a ^ {b[3:0], s}};
        endcase
    endfunction

    assign {alu_cout[0], alu_out[0]} = ref_alu(alu_a[0], alu_b[0], alu_sel[0]);
    assign {alu_cout[1], alu_out[1]} = ref_alu(alu_a[1], alu_b[1], alu_sel[1]) ^
        ((busy[1] && !rsp_valid[1] && drv_cyc < 3) ? 9'h15A : 9'h000);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        drv_cyc <= (!rst && busy[1] && !rsp_valid[1]) ? drv_cyc + 1 : 0;
    end

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses when rsp_valid rises, checks hold and counts.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pv[d] = 1'b0;
            end else begin
                if (pv[d] && pr) begin
                    cnt_exp[d]++;
                    hs_cnt[d]++;
                    start[d] = cyc;
                    chk($sformatf("count%0d", d), rsp_count[d], cnt_exp[d]);
                    chk($sformatf("valid_drop%0d", d), rsp_valid[d], 0);
                end else if (pv[d]) begin
                    chk($sformatf("hold_valid%0d", d), rsp_valid[d], 1);
                    chk($sformatf("hold_data%0d", d), rsp_data[d], held[d].d);
                    chk($sformatf("hold_cout%0d", d), rsp_cout[d], held[d].c);
                    chk($sformatf("hold_sel%0d", d), rsp_sel[d], held[d].s);
                    chk($sformatf("hold_last%0d", d), rsp_last[d], held[d].l);
                end else if (rsp_valid[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("unexpected_rsp%0d", d), 1, 0);
                    end else begin
                        exp_t e;
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        held[d] = e;
                        chk($sformatf("data%0d", d), rsp_data[d], e.d);
                        chk($sformatf("cout%0d", d), rsp_cout[d], e.c);
                        chk($sformatf("sel%0d", d), rsp_sel[d], e.s);
                        chk($sformatf("last%0d", d), rsp_last[d], e.l);
                        chk($sformatf("latency%0d", d), cyc - start[d], setl[d]);
                    end
                end
                pv[d] = rsp_valid[d];
            end
        end
        case (rdy_mode)
            0:       pr = 1'b1;
            1:       pr = ($urandom_range(0, 2) != 0);
            default: pr = 1'b0;
        endcase
        rsp_ready = pr;
    end

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", rsp_valid[d], 0);
            chk("rst_last", rsp_last[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_ready", cmd_ready[d], 1);
            chk("rst_alu", {alu_a[d], alu_b[d], alu_sel[d]}, 0);
            chk("rst_rsp", {rsp_data[d], rsp_cout[d], rsp_sel[d]}, 0);
            chk("rst_count", rsp_count[d], 0);
        end
    endtask

    task automatic send(input logic sw, input logic [3:0] sel,
                        input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!(cmd_ready[0] && cmd_ready[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", 1, 0);
        cmd_valid = 1'b1; cmd_sweep = sw; cmd_sel = sel; cmd_a = a; cmd_b = b;
        for (int k = 0; k < (sw ? 16 : 1); k++) begin
            exp_t e;
            logic [3:0] s = sw ? 4'(k) : sel;
            {e.c, e.d} = ref_alu(a, b, s);
            e.s = s;
            e.l = !sw || (k == 15);
            q0.push_back(e);
            q1.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        start[0] = cyc;
        start[1] = cyc;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (!(q0.size() == 0 && q1.size() == 0 && cmd_ready[0] && cmd_ready[1])
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int n;
        int base;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        rdy_mode = 0;

        // Full sweep straight after reset: 16 responses, and-op at sel 8.
        send(1'b1, 4'h3, 8'h0A, 8'h12);
        drain();
        chk("sweep_count0", rsp_count[0], 16);
        chk("sweep_count1", rsp_count[1], 16);

        send(1'b0, 4'h0, 8'h0A, 8'h12);
        send(1'b0, 4'h0, 8'hFF, 8'h02);
        drain();

        // Backpressure: hold ready low and present a second command meanwhile.
        rdy_mode = 2;
        send(1'b0, 4'h8, 8'h33, 8'h0F);
        n = 0;
        while (!(rsp_valid[0] && rsp_valid[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_timeout", 1, 0);
        cmd_valid = 1'b1; cmd_sweep = 1'b1; cmd_a = 8'h77; cmd_b = 8'h11;
        repeat (5) begin
            @(negedge clk);
            chk("bp_cmd_ready0", cmd_ready[0], 0);
            chk("bp_cmd_ready1", cmd_ready[1], 0);
        end
        cmd_valid = 1'b0;
        rdy_mode = 0;
        drain();

        rdy_mode = 1;
        repeat (30)
            send(($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom), 8'($urandom));
        drain();

        // Reset mid-sweep after three handshakes on the fast instance.
        rdy_mode = 0;
        base = hs_cnt[0];
        send(1'b1, 4'h0, 8'h5C, 8'hA3);
        n = 0;
        while (hs_cnt[0] - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rst_sweep_timeout", 1, 0);
        rst = 1'b1;
        @(negedge clk);
        q0.delete();
        q1.delete();
        cnt_exp[0] = 8'd0;
        cnt_exp[1] = 8'd0;
        check_reset();
        rst = 1'b0;
        repeat (60) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_busy", busy[d], 0);
            chk("post_rst_valid", rsp_valid[d], 0);
            chk("post_rst_count", rsp_count[d], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
